// File: rtl/program_loader_encoder.sv
// Field-level RV32I instruction encoder feeding an acknowledged instruction-memory
// write port; words land at consecutive addresses starting at BASE_ADDR.
module program_loader_encoder #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            req_class_i,
  input  logic [2:0]            funct3_i,
  input  logic [6:0]            funct7_i,
  input  logic [4:0]            rd_i,
  input  logic [4:0]            rs1_i,
  input  logic [4:0]            rs2_i,
  input  logic [31:0]           imm_i,
  input  logic                  req_last_i,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_ack_i,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  full_o,
  output logic                  err_o,
  output logic                  done_o
);

  localparam logic [2:0] C_R = 3'b000, C_I = 3'b001, C_LUI = 3'b010, C_JALR = 3'b011,
                         C_B = 3'b100, C_LW = 3'b101, C_SW = 3'b110, C_JAL = 3'b111;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef struct packed {
    logic [2:0]  cls;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        last;
  } req_t;

  typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_ENCODE, S_WRITE, S_DONE} state_t;

  state_t               state, next_state;
  req_t                 req_q;
  logic [ADDR_WIDTH:0]  count_q;
  logic                 err_q;
  logic                 accept, misaligned, full;

  function automatic logic [31:0] encode(input req_t r);
    logic [31:0] w;
    case (r.cls)
      C_R:    w = {r.f7, r.rs2, r.rs1, r.f3, r.rd, 7'h33};
      // Shift-immediates carry funct7 in the upper bits and a 5-bit shamt
      C_I:    w = (r.f3[1:0] == 2'b01) ? {r.f7, r.imm[4:0], r.rs1, r.f3, r.rd, 7'h13}
                                       : {r.imm[11:0], r.rs1, r.f3, r.rd, 7'h13};
      C_LUI:  w = {r.imm[31:12], r.rd, 7'h37};
      C_JALR: w = {r.imm[11:0], r.rs1, 3'b000, r.rd, 7'h67};
      C_B:    w = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.f3, r.imm[4:1], r.imm[11], 7'h63};
      C_LW:   w = {r.imm[11:0], r.rs1, 3'b010, r.rd, 7'h03};
      C_SW:   w = {r.imm[11:5], r.rs2, r.rs1, 3'b010, r.imm[4:0], 7'h23};
      default: w = {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12], r.rd, 7'h6F};
    endcase
    return w;
  endfunction

  assign full        = (count_q == FULL_CNT);
  assign accept      = (state == S_ACCEPT) && req_valid_i && !full;
  // Branch/jump targets must be halfword aligned; those requests are dropped
  assign misaligned  = ((req_q.cls == C_B) || (req_q.cls == C_JAL)) && req_q.imm[0];

  assign req_ready_o = (state == S_ACCEPT) && !full;
  assign mem_we_o    = (state == S_WRITE);
  assign done_o      = (state == S_DONE);
  assign count_o     = count_q;
  assign full_o      = full;
  assign err_o       = err_q;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start_i) next_state = S_ACCEPT;
      S_ACCEPT: if (accept) next_state = S_ENCODE;
      S_ENCODE: if (misaligned) next_state = req_q.last ? S_DONE : S_ACCEPT;
                else next_state = S_WRITE;
      S_WRITE:  if (mem_ack_i) next_state = req_q.last ? S_DONE : S_ACCEPT;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      req_q       <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      state <= next_state;
      if (state == S_IDLE && start_i) begin
        count_q <= '0;
        err_q   <= 1'b0;
      end
      if (accept)
        req_q <= '{cls: req_class_i, f3: funct3_i, f7: funct7_i, rd: rd_i, rs1: rs1_i,
                   rs2: rs2_i, imm: imm_i, last: req_last_i};
      if (state == S_ENCODE) begin
        if (misaligned) err_q <= 1'b1;
        else begin
          mem_wdata_o <= encode(req_q);
          mem_addr_o  <= BASE_ADDR + {{(29-ADDR_WIDTH){1'b0}}, count_q, 2'b00};
        end
      end
      if (state == S_WRITE && mem_ack_i) count_q <= count_q + 1'b1;
    end
  end

endmodule
